// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] pc_plus4;
        logic [WORD_W-1:0] instruction;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched entries. Flush empties it and wins over push;
// a pop presented in the flush cycle is considered delivered.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               entry,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   slots [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, push and pop share a slot; the head is read before the edge.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) slots[wr_ptr] <= entry;
    end

    assign head = (count != '0) ? slots[rd_ptr] : '0;
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, push/redirect control and optional bound fault.
// Optional out-of-range fetch detection is enabled by FETCH_BOUND_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          MEM_WORDS   = 128
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    output logic        fetch_fault
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    fetch_entry_t  entry;
    fetch_entry_t  head;
    logic          pop;
    logic          push;
    logic          space;
    logic          unused_bits;

    assign pop   = out_valid && out_ready;
    assign space = (count < CW'(QUEUE_DEPTH)) || pop;

`ifdef FETCH_BOUND_CHECK_EN
    logic fault;
    logic in_range;
    logic target_in_range;

    assign in_range        = pc[31:2] < 30'(MEM_WORDS);
    assign target_in_range = branch_address[31:2] < 30'(MEM_WORDS);
    assign push            = !branch_taken && !fault && space && in_range;

    // Sticky until a redirect lands back inside memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (branch_taken) begin
            fault <= fault && !target_in_range;
        end else if (!fault && space && !in_range) begin
            fault <= 1'b1;
        end
    end

    assign fetch_fault = fault;
    assign unused_bits = ^branch_address[1:0];
`else
    assign push        = !branch_taken && space;
    assign fetch_fault = 1'b0;
    assign unused_bits = ^{branch_address[1:0], (MEM_WORDS == 0)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= {branch_address[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    assign entry = '{pc_plus4: pc + PC_STEP, instruction: imem_instruction};

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_taken),
        .entry (entry),
        .head  (head),
        .count (count)
    );

    assign imem_address    = pc;
    assign out_valid       = (count != '0);
    assign out_pc          = head.pc_plus4;
    assign out_instruction = head.instruction;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing checks plus a
// scoreboard of the expected in-order instruction stream.
module tb_fetch_unit;
    localparam int MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        fetch_fault;

    logic [31:0] mem [MEM_WORDS];
    logic [63:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2),
        .MEM_WORDS   (MEM_WORDS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .branch_taken     (branch_taken),
        .branch_address   (branch_address),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction),
        .fetch_fault      (fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr[31:2] < 30'(MEM_WORDS)) return mem[addr[8:2]];
        return 32'hBAD0_0000 ^ addr;
    endfunction

    assign imem_instruction = mem_word(imem_address);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected program-order stream starting at a (re)start address.
    task automatic fill(input logic [31:0] start);
        logic [31:0] addr;
        addr = start;
        for (int i = 0; i < 64; i++) begin
`ifdef FETCH_BOUND_CHECK_EN
            if (addr[31:2] >= 30'(MEM_WORDS)) break;
`endif
            exp_q.push_back({addr + 32'd4, mem_word(addr)});
            addr = addr + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("sb_entry", {out_pc, out_instruction}, exp_q.pop_front());
        end
        if (rst) begin
            exp_q.delete();
            fill(32'h0000_0000);
        end else if (branch_taken) begin
            exp_q.delete();
            fill({branch_address[31:2], 2'b00});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem"}, imem_address, 32'h0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_pc"}, out_pc, 32'h0);
        check({tag, "_instr"}, out_instruction, 32'h0);
        check({tag, "_fault"}, fetch_fault, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = {16'hA5A5, 16'(i * 37)};
        mem[0] = 32'hE3A00014;
        mem[1] = 32'hE3A01A01;
        rst = 1'b1;
        out_ready = 1'b0;
        branch_taken = 1'b0;
        branch_address = 32'h0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Streaming from reset release
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stream1_valid", out_valid, 1'b1);
        check("stream1", {out_pc, out_instruction}, {32'd4, 32'hE3A00014});
        tick();
        check("stream2", {out_pc, out_instruction}, {32'd8, 32'hE3A01A01});
        check("stream2_imem", imem_address, 32'd8);

        // Backpressure from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_imem", imem_address, (i == 0) ? 32'd4 : 32'd8);
            check("bp_head", {out_valid, out_pc, out_instruction}, {1'b1, 32'd4, 32'hE3A00014});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Redirect while full
        branch_taken = 1'b1;
        branch_address = 32'h40;
        tick();
        check("redir_valid", out_valid, 1'b0);
        check("redir_imem", imem_address, 32'h40);
        branch_taken = 1'b0;
        tick();
        check("redir_head", {out_valid, out_pc, out_instruction}, {1'b1, 32'h44, mem[16]});

        // Redirect with pop in the same cycle, misaligned target
        out_ready = 1'b1;
        branch_taken = 1'b1;
        branch_address = 32'h43;
        tick();
        check("misalign_imem", imem_address, 32'h40);
        check("misalign_valid", out_valid, 1'b0);
        branch_taken = 1'b0;
        tick();
        check("misalign_head", {out_pc, out_instruction}, {32'h44, mem[16]});
        tick();

        // Reset together with a redirect
        rst = 1'b1;
        branch_taken = 1'b1;
        branch_address = 32'h80;
        tick();
        check_reset_outputs("rst_wins");
        rst = 1'b0;
        branch_taken = 1'b0;
        tick();
        tick();

`ifndef FETCH_BOUND_CHECK_EN
        // PC wraps past the top of the address space
        branch_taken = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        tick();
        check("wrap_imem_top", imem_address, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        tick();
        check("wrap_imem", imem_address, 32'h0);
        check("wrap_head", {out_valid, out_pc}, {1'b1, 32'h0});
        tick();
`endif

        // Random backpressure with periodic random redirects
        for (int c = 0; c < 160; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (c % 16 == 15) begin
                branch_taken = 1'b1;
                branch_address = 32'($urandom_range(0, 60)) * 32'd4 + 32'($urandom_range(0, 3));
            end else begin
                branch_taken = 1'b0;
            end
            tick();
        end
        branch_taken = 1'b0;

`ifdef FETCH_BOUND_CHECK_EN
        // Run off the end of instruction memory
        out_ready = 1'b1;
        branch_taken = 1'b1;
        branch_address = 32'h1FC;
        tick();
        check("bound_imem_start", imem_address, 32'h1FC);
        branch_taken = 1'b0;
        tick();
        check("bound_last", {out_valid, out_pc, out_instruction}, {1'b1, 32'h200, mem[127]});
        check("bound_fault_low", fetch_fault, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bound_fault", fetch_fault, 1'b1);
            check("bound_hold", imem_address, 32'h200);
            check("bound_empty", out_valid, 1'b0);
        end
        branch_taken = 1'b1;
        branch_address = 32'h0;
        tick();
        check("bound_clear", fetch_fault, 1'b0);
        check("bound_clear_imem", imem_address, 32'h0);
        branch_taken = 1'b0;
`endif

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the ARM-subset pipeline. Owns the program counter, reads the word-addressed instruction memory and buffers fetched words in a small flushable queue. Hands instructions to decode over a valid/ready handshake. Accepts branch redirects from execute, which flush all in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `QUEUE_DEPTH`, default 2: fetch queue entries. Legal values are 1 to 4.
- `MEM_WORDS`, default 128: instruction memory depth in 32-bit words.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `imem_address`, output, 32: byte address to the instruction memory. Always equals the current PC.
- `imem_instruction`, input, 32: instruction word. Combinational read of word `imem_address/4`.
- `branch_taken`, input, 1: redirect request from execute.
- `branch_address`, input, 32: redirect target, byte address.
- `out_valid`, output, 1: queue head is valid.
- `out_ready`, input, 1: decode accepts the head this cycle.
- `out_pc`, output, 32: PC+4 of the head instruction.
- `out_instruction`, output, 32: head instruction word.
- `fetch_fault`, output, 1: PC is outside instruction memory. Sticky; only present in behaviour under FETCH_BOUND_CHECK_EN.

## Operation
- State:
  - `pc` register (32 bits).
  - Queue of `{pc_plus4, instruction}` entries, each 64 bits.
  - Occupancy `count`, range 0 to QUEUE_DEPTH.
  - One fault flag.
- `pop` = `out_valid && out_ready`.
- `push` = `!branch_taken && !fault && (count < QUEUE_DEPTH || pop)`.
  - When full, a push is allowed in the same cycle as a pop. Count is unchanged.
- On `push`:
  - Enqueue `{pc+4, imem_instruction}`.
  - `pc <= pc + 4`.
- When no push occurs, `pc` holds. This covers a full queue with no pop, and a fault.
- Redirect has priority over all other activity:
  - On `branch_taken`: `pc <= branch_address`, queue cleared (`count <= 0`), no push that cycle.
  - A pop in the same cycle still completes, because the head was presented. All other entries are discarded.
  - `branch_address` bits [1:0] are ignored. The PC is forced word-aligned: `{branch_address[31:2], 2'b00}`.
- PC arithmetic is 32-bit unsigned and wraps from 32'hFFFF_FFFC to 0. There is no saturation.
- Output mux: `out_*` come from the queue head. They are X-free: zero when `count == 0`.
- Reset (`rst` high at an edge), also mid-operation:
  - `pc <= RESET_PC`.
  - `count <= 0`, read/write pointers <= 0.
  - Fault cleared.
  - `rst` overrides `branch_taken`.
- Reset values of outputs:
  - `imem_address` = RESET_PC.
  - `out_valid` = 0.
  - `out_pc` = 0.
  - `out_instruction` = 0.
  - `fetch_fault` = 0.

## Timing
- Instruction memory read is zero-latency. Fetch of the word at `pc` and the queue write happen at the same edge.
- From reset release to first `out_valid`:
  - The first edge with `rst` low pushes the word at RESET_PC.
  - `out_valid` rises in the following cycle.
- Redirect latency:
  - `branch_taken` is sampled at edge N.
  - Target word is pushed at edge N+1.
  - `out_valid` is high with the target from cycle N+1 onward. So `out_valid` is low for exactly one cycle after a redirect.
- Steady-state throughput is one instruction per cycle with `out_ready` held high.
- `out_*` are stable while `out_valid && !out_ready`, unless `branch_taken` or `rst` is asserted.

## Configuration
- Macro: `FETCH_BOUND_CHECK_EN`.
- Defined:
  - At a cycle where push would occur and `pc[31:2] >= MEM_WORDS`, no push happens, `pc` holds, and the fault flag sets.
  - `fetch_fault` stays high until `branch_taken` to an in-range target, or `rst`.
  - Entries already queued still drain normally.
- Undefined:
  - No check is performed and `fetch_fault` is tied to 0.
  - Out-of-range addresses are passed to memory unchanged.

## Structure
- Package `fetch_pkg`:
  - `WORD_W = 32`.
  - `fetch_entry_t` struct `{pc_plus4, instruction}`.
  - `PC_STEP = 4`.
- Sub-module `fetch_queue`: a circular FIFO of `fetch_entry_t`, parameterised by depth.
  - Ports: push, pop, flush, head, count.
  - Flush has priority over push, and the simultaneous pop is still counted as completed.
- `fetch_unit` holds the PC, push/redirect logic and the fault flag.

## Test plan
- Reset and streaming:
  - Stimulus: memory word 0 = 32'hE3A00014, word 1 = 32'hE3A01A01; `out_ready` = 1.
  - Required: `out_valid` rises in the 2nd cycle after release with `out_pc`=4 and `out_instruction`=E3A00014. The next cycle shows `out_pc`=8 and E3A01A01.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 5 cycles.
  - Required: `count` reaches 2, `pc` freezes at 8, head is unchanged. After release, entries drain in order with no loss or duplication.
- Redirect:
  - Stimulus: assert `branch_taken` with `branch_address`=32'h40 while the queue is full.
  - Required: queue is empty next cycle with `out_valid`=0. The following cycle has `out_pc`=32'h44, instruction = word 16.
- Simultaneous events:
  - Stimulus: `branch_taken` and `pop` in the same cycle, then `rst` together with `branch_taken`.
  - Required: the pop completes. Reset wins, giving `pc`=0 and all outputs at reset values.
- Misaligned target:
  - Stimulus: `branch_address`=32'h43.
  - Required: `imem_address`=32'h40.
- Bounds (with `FETCH_BOUND_CHECK_EN`):
  - Stimulus: branch to 32'h1FC, then run.
  - Required: word 127 is delivered. `fetch_fault`=1 with `pc` held at 32'h200. A subsequent branch to 0 clears it.
